// File: rtl/uart_rx_word.sv
// uart_rx_word: 16x-oversampled serial receiver that rebuilds 12-bit words from byte pairs.
// The MSB byte carries {4'b0000, d[11:8]} and the LSB byte carries d[7:0]. Framing, header and
// inter-byte timeout errors are each reported as a one-cycle registered pulse.
module uart_rx_word #(
  parameter int unsigned Nbits  = 8,
  parameter int unsigned Sticks = 16,
  parameter int unsigned TWidth = 12,
  parameter int unsigned TMax   = 2047
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        tick_i,
  input  logic        rx_i,
  output logic [11:0] dout_o,
  output logic        rdy_o,
  output logic        ferr_o,
  output logic        herr_o,
  output logic        toerr_o
);

  localparam int unsigned SW = $clog2(Sticks);
  localparam int unsigned NW = $clog2(Nbits);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e              state_q, state_d;
  logic                rx_meta_q, rxs_q;
  logic [SW-1:0]       s_q, s_d;
  logic [NW-1:0]       n_q, n_d;
  logic [Nbits-1:0]    shreg_q, shreg_d;
  logic                pair_q, pair_d;  // 0: expecting MSB byte, 1: expecting LSB byte
  logic [3:0]          nib_q, nib_d;
  logic [TWidth-1:0]   to_q, to_d;
  logic [11:0]         dout_q, dout_d;
  logic                rdy_q, rdy_d, ferr_q, ferr_d, herr_q, herr_d, toerr_q, toerr_d;

  // Next-state logic for the bit FSM, byte pairing and the inter-byte timeout.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    shreg_d = shreg_q;
    pair_d  = pair_q;
    nib_d   = nib_q;
    to_d    = to_q;
    dout_d  = dout_q;
    rdy_d   = 1'b0;
    ferr_d  = 1'b0;
    herr_d  = 1'b0;
    toerr_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs_q) begin
          // Start edge: the timeout counter freezes here.
          state_d = StStart;
          s_d     = '0;
        end else if (tick_i && pair_q) begin
          to_d = to_q + 1'b1;
          if (to_d == TWidth'(TMax)) begin
            toerr_d = 1'b1;
            pair_d  = 1'b0;
          end
        end
      end
      StStart: begin
        if (tick_i) begin
          if (rxs_q) begin
            state_d = StIdle;
          end else if (s_q == SW'(Sticks / 2 - 1)) begin
            state_d = StData;
            s_d     = '0;
            n_d     = '0;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick_i) begin
          if (s_q == SW'(Sticks - 1)) begin
            shreg_d = {rxs_q, shreg_q[Nbits-1:1]};
            s_d     = '0;
            if (n_q == NW'(Nbits - 1)) state_d = StStop;
            else                       n_d     = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick_i) begin
          if (s_q == SW'(Sticks - 1)) begin
            state_d = StIdle;
            if (!rxs_q) begin
              ferr_d = 1'b1;
              pair_d = 1'b0;
            end else if (!pair_q) begin
              if (|shreg_q[Nbits-1:4]) begin
                herr_d = 1'b1;
              end else begin
                nib_d  = shreg_q[3:0];
                pair_d = 1'b1;
                to_d   = '0;
              end
            end else begin
              dout_d = {nib_q, shreg_q[7:0]};
              rdy_d  = 1'b1;
              pair_d = 1'b0;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset; rx passes a 2-flop synchronizer.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
      state_q   <= StIdle;
      s_q       <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      pair_q    <= 1'b0;
      nib_q     <= '0;
      to_q      <= '0;
      dout_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      herr_q    <= 1'b0;
      toerr_q   <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rxs_q     <= rx_meta_q;
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      pair_q    <= pair_d;
      nib_q     <= nib_d;
      to_q      <= to_d;
      dout_q    <= dout_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
      herr_q    <= herr_d;
      toerr_q   <= toerr_d;
    end
  end

  assign dout_o  = dout_q;
  assign rdy_o   = rdy_q;
  assign ferr_o  = ferr_q;
  assign herr_o  = herr_q;
  assign toerr_o = toerr_q;

endmodule
